// File: rtl/hwpf_stride_engine.sv
// Single stride hardware-prefetch engine feeding one port of the prefetch request arbiter.
// Optional HWPF_STRIDE_REARM_EN: on completion the base moves to the last issued line.
package hwpf_stride_engine_pkg;

  localparam int unsigned HPDCACHE_PA_WIDTH   = 49;
  localparam int unsigned HPDCACHE_TID_WIDTH  = 8;
  localparam int unsigned HPDCACHE_WORD_WIDTH = 64;

  typedef enum logic [3:0] {
    HPDCACHE_REQ_LOAD         = 4'h0,
    HPDCACHE_REQ_STORE        = 4'h1,
    HPDCACHE_REQ_CMO_PREFETCH = 4'h8
  } hpdcache_req_op_t;

  typedef struct packed {
    hpdcache_req_op_t                  op;
    logic [HPDCACHE_PA_WIDTH-1:0]      addr;
    logic [HPDCACHE_WORD_WIDTH-1:0]    wdata;
    logic [HPDCACHE_WORD_WIDTH/8-1:0]  be;
    logic [2:0]                        size;
    logic [HPDCACHE_TID_WIDTH-1:0]     tid;
    logic                              need_rsp;
    logic                              uncacheable;
  } hpdcache_req_t;

endpackage

module hwpf_stride_engine
  import hwpf_stride_engine_pkg::*;
#(
  parameter int unsigned HWPF_ID      = 0,
  parameter int unsigned ADDR_WIDTH   = 49,
  parameter int unsigned CLINE_OFFSET = 6,
  parameter int unsigned MAX_INFLIGHT = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cfg_we_i,
  input  logic                  cfg_enable_i,
  input  logic [ADDR_WIDTH-1:0] cfg_base_i,
  input  logic [15:0]           cfg_stride_i,
  input  logic [7:0]            cfg_nlines_i,
  input  logic                  snoop_valid_i,
  input  logic [ADDR_WIDTH-1:0] snoop_addr_i,
  output logic                  req_valid_o,
  input  logic                  req_ready_i,
  output hpdcache_req_t         req_o,
  input  logic                  rsp_valid_i,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int unsigned LW   = ADDR_WIDTH - CLINE_OFFSET;
  localparam int unsigned IFW  = 4;
  localparam int unsigned REMW = 9;

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_ISSUE, S_DRAIN} state_t;

  state_t          state_q, state_d;
  logic [LW-1:0]   base_q, base_d;
  logic [15:0]     stride_q, stride_d;
  logic [7:0]      nlines_q, nlines_d;
  logic            enable_q, enable_d;
  logic [LW-1:0]   cur_q, cur_d;
  logic [REMW-1:0] rem_q, rem_d;
  logic [IFW-1:0]  inflight_q, inflight_d;
  logic            abort_q, abort_d;
  logic            req_valid_q, req_valid_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            hs, rsp_take, trigger;
`ifdef HWPF_STRIDE_REARM_EN
  logic [LW-1:0]   last_q, last_d;
`endif

  logic unused_ok;
  assign unused_ok = ^{snoop_addr_i[CLINE_OFFSET-1:0], cfg_base_i[CLINE_OFFSET-1:0]};

  assign hs       = req_valid_q & req_ready_i;
  assign rsp_take = rsp_valid_i && (inflight_q != '0);
  assign trigger  = snoop_valid_i && (snoop_addr_i[ADDR_WIDTH-1:CLINE_OFFSET] == base_q);

  // Next-state, counters and registered outputs
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    stride_d   = stride_q;
    nlines_d   = nlines_q;
    enable_d   = enable_q;
    cur_d      = cur_q;
    rem_d      = rem_q;
    inflight_d = inflight_q;
    abort_d    = abort_q;
    done_d     = 1'b0;
`ifdef HWPF_STRIDE_REARM_EN
    last_d     = last_q;
`endif

    // A handshake and a response in the same cycle cancel out
    if (hs && !rsp_take)      inflight_d = inflight_q + IFW'(1);
    else if (!hs && rsp_take) inflight_d = inflight_q - IFW'(1);

    unique case (state_q)
      S_IDLE: begin
        if (cfg_we_i && cfg_enable_i) state_d = S_ARMED;
      end
      S_ARMED: begin
        if (cfg_we_i) begin
          if (!cfg_enable_i) state_d = S_IDLE;
        end else if (trigger) begin
          cur_d   = base_q + LW'(stride_q);
          rem_d   = REMW'(nlines_q) + REMW'(1);
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (hs) begin
          cur_d = cur_q + LW'(stride_q);
          rem_d = rem_q - REMW'(1);
`ifdef HWPF_STRIDE_REARM_EN
          last_d = cur_q;
`endif
          if (rem_q == REMW'(1)) state_d = S_DRAIN;
        end
        if (cfg_we_i) begin
          abort_d = 1'b1;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (cfg_we_i) begin
          abort_d = 1'b1;
        end else if (inflight_q == '0) begin
          done_d  = !abort_q;
          abort_d = 1'b0;
          state_d = enable_q ? S_ARMED : S_IDLE;
`ifdef HWPF_STRIDE_REARM_EN
          if (enable_q && !abort_q) base_d = last_q;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Configuration writes are accepted in every state
    if (cfg_we_i) begin
      base_d   = cfg_base_i[ADDR_WIDTH-1:CLINE_OFFSET];
      stride_d = cfg_stride_i;
      nlines_d = cfg_nlines_i;
      enable_d = cfg_enable_i;
    end

    req_valid_d = (state_d == S_ISSUE) && (inflight_d < IFW'(MAX_INFLIGHT));
    busy_d      = (state_d == S_ISSUE) || (state_d == S_DRAIN) || (inflight_d != '0);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      stride_q    <= '0;
      nlines_q    <= '0;
      enable_q    <= 1'b0;
      cur_q       <= '0;
      rem_q       <= '0;
      inflight_q  <= '0;
      abort_q     <= 1'b0;
      req_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef HWPF_STRIDE_REARM_EN
      last_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      stride_q    <= stride_d;
      nlines_q    <= nlines_d;
      enable_q    <= enable_d;
      cur_q       <= cur_d;
      rem_q       <= rem_d;
      inflight_q  <= inflight_d;
      abort_q     <= abort_d;
      req_valid_q <= req_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef HWPF_STRIDE_REARM_EN
      last_q      <= last_d;
`endif
    end
  end

  // Request payload comes straight from the current-line register
  always_comb begin
    req_o          = '0;
    req_o.op       = HPDCACHE_REQ_CMO_PREFETCH;
    req_o.addr     = HPDCACHE_PA_WIDTH'({cur_q, {CLINE_OFFSET{1'b0}}});
    req_o.tid      = HPDCACHE_TID_WIDTH'(HWPF_ID);
    req_o.need_rsp = 1'b1;
  end

  assign req_valid_o = req_valid_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule

// File: doc/hwpf_stride_engine.md
Name: hwpf_stride_engine

Overview:
- Single stride hardware-prefetch engine; one instance per requester port of the hardware-prefetcher request arbiter, directly upstream of it.
- Programmed with a base address, a stride and a line count. Arms, then waits for a demand access to the base cacheline.
- On trigger, issues cacheline prefetch requests at base+stride, base+2·stride, …
- Tracks in-flight prefetches from the responses returned by the arbiter's TID demux.

Parameters:
- HWPF_ID, 0: engine identifier, driven on the request tid field.
- ADDR_WIDTH, 49: byte-address width.
- CLINE_OFFSET, 6: log2 of cacheline size in bytes.
- MAX_INFLIGHT, 4: maximum outstanding prefetches, 1..15.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- cfg_we_i  in  1  configuration write strobe.
- cfg_enable_i  in  1  arm the engine after the write.
- cfg_base_i  in  ADDR_WIDTH  base byte address.
- cfg_stride_i  in  16  stride in cachelines, unsigned.
- cfg_nlines_i  in  8  lines to prefetch minus 1.
- snoop_valid_i  in  1  demand access observed.
- snoop_addr_i  in  ADDR_WIDTH  demand byte address.
- req_valid_o  out  1  prefetch request valid.
- req_ready_i  in  1  arbiter ready.
- req_o  out  $bits(hpdcache_req_t)  request: op=PREFETCH, addr=current line address (offset bits 0), tid=HWPF_ID, need_rsp=1, all other fields 0.
- rsp_valid_i  in  1  response for this engine (already TID-demuxed).
- busy_o  out  1  state is not IDLE or ARMED, or inflight is non-zero.
- done_o  out  1  one-cycle pulse when a prefetch sequence completes.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high. rst_i clears all state in the cycle it is sampled, including mid-sequence.
- Reset values: state=IDLE, req_valid_o=0, busy_o=0, done_o=0, inflight=0. Config registers reset to 0.
- State IDLE:
  - cfg_we_i latches base, stride and nlines.
  - Goes to ARMED if cfg_enable_i=1, else stays IDLE.
- State ARMED:
  - Trigger when snoop_valid_i and snoop_addr_i[ADDR_WIDTH-1:CLINE_OFFSET] equals base[ADDR_WIDTH-1:CLINE_OFFSET].
  - On trigger: cur = base_line + stride (line units), remaining = nlines+1, go to ISSUE.
  - cfg_we_i in ARMED re-latches config; cfg_enable_i=0 returns to IDLE.
  - If trigger and cfg_we_i occur in the same cycle, cfg_we_i wins and no trigger is taken.
- State ISSUE:
  - req_valid_o = (inflight < MAX_INFLIGHT).
  - req_o.addr = {cur, CLINE_OFFSET zeros}. req_o is stable while req_valid_o=1 and req_ready_i=0.
  - req_valid_o never deasserts without a handshake, except on reset or cfg_we_i.
  - On handshake (req_valid_o & req_ready_i): inflight+1, cur += stride, remaining-1.
  - When remaining reaches 0 after a handshake, go to DRAIN.
- Address arithmetic: cur is a line address of ADDR_WIDTH-CLINE_OFFSET bits; additions wrap modulo 2^(ADDR_WIDTH-CLINE_OFFSET). A stride of 0 is legal and prefetches the base+0 line repeatedly.
- State DRAIN:
  - Wait for inflight==0.
  - Then pulse done_o for exactly one cycle and go to ARMED (if still enabled) or IDLE.
- Responses:
  - rsp_valid_i decrements inflight in any state.
  - Handshake and response in the same cycle leave inflight unchanged.
  - rsp_valid_i with inflight==0 is ignored; counter saturates at 0.
- cfg_we_i in ISSUE or DRAIN (abort):
  - req_valid_o drops the next cycle and no further requests are issued.
  - New config is latched and the engine goes to DRAIN.
  - After draining, done_o is not pulsed; the engine goes to ARMED or IDLE per the new cfg_enable_i.
- Latency:
  - First req_valid_o is asserted the cycle after the trigger.
  - Back-to-back issue at 1 request/cycle when ready and under the in-flight limit.

Optional Feature:
- Macro: HWPF_STRIDE_REARM_EN.
- Defined: on sequence completion (DRAIN→ARMED), base is updated to the last issued line address. The next trigger therefore continues the stream, with the snoop match against the new base.
- Not defined: base is unchanged and the engine re-arms on the original base.

Test Plan:
- base=0x1000, stride=2, nlines=3, enable; snoop 0x1008; ready=1, responses after 2 cycles → 4 requests at 0x1080, 0x1100, 0x1180, 0x1200, tid=HWPF_ID, done_o pulses once, back to ARMED.
- MAX_INFLIGHT=2, no responses, nlines=5 → exactly 2 handshakes, req_valid_o=0. Single rsp_valid_i → exactly 1 more request issued.
- ready held 0 for 5 cycles while req_valid_o=1 → req_o stable. Handshake on cycle 6 → address advances by the stride.
- Snoop 0x1040 (different line) while armed on 0x1000 → no request. Snoop 0x103F → trigger.
- cfg_we_i mid-ISSUE after 2 of 6 requests → no 3rd request, waits for 2 responses, no done_o, returns to ARMED with the new base.
- rst_i asserted in ISSUE with inflight=3 → next cycle req_valid_o=0, busy_o=0, state IDLE. With HWPF_STRIDE_REARM_EN: second trigger at 0x1200 continues from 0x1280.
